// File: rtl/muldiv_seq_ctrl.sv
// Iterative multiply/divide sequencer: shift-add MUL/MULH, restoring DIV/REM on one shared external adder.
// Latency: WIDTH+1 cycles accept->out_valid; divide-by-zero (and signed overflow) 1 cycle; signed ops +1.
// Backpressure: single op in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Optional feature macro: MULDIV_SIGNED_EN (signed operation when sgn=1; sgn ignored otherwise).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake; op, sgn, opa, opb sampled on accept
//   out_valid/out_ready   result handshake; result valid only while out_valid
//   busy                  operation in progress (CALC/FIX/DONE)
//   add1, add0, carry_in  operands for the external (WIDTH+1)-bit adder, zero outside CALC
//   sum                   combinational adder result for the current cycle
module muldiv_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH:0]   add1,
    output logic [WIDTH:0]   add0,
    output logic             carry_in,
    input  logic [WIDTH:0]   sum
);

    // S_FIX is only reachable when the signed feature is built in.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // acc doubles as the divide remainder, mq as the divide quotient.
    // oper holds the add0 operand: multiplicand for MUL, divisor for DIV.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] oper;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_r;

    logic             accept;
    logic             short_path;
    logic             ovf;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   div_t;

    assign accept = (state == S_IDLE) && in_valid;
    assign div_t  = {acc[WIDTH-1:0], mq[WIDTH-1]};

`ifdef MULDIV_SIGNED_EN
    logic                 a_neg, b_neg;
    logic                 sgn_r, neg_lo, neg_hi;
    logic [2*WIDTH-1:0]   prod_neg;

    assign a_neg = sgn & opa[WIDTH-1];
    assign b_neg = sgn & opb[WIDTH-1];
    // Magnitudes are formed locally so the shared adder is never needed outside CALC.
    assign a_mag = a_neg ? (~opa + WIDTH'(1)) : opa;
    assign b_mag = b_neg ? (~opb + WIDTH'(1)) : opb;
    assign ovf   = sgn & op[1] & (opa == {1'b1, {(WIDTH-1){1'b0}}}) & (&opb);
    assign prod_neg = ~{acc[WIDTH-1:0], mq} + (2*WIDTH)'(1);
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign a_mag      = opa;
    assign b_mag      = opb;
    assign ovf        = 1'b0;
`endif

    // Divide-by-zero and signed overflow have fixed answers: skip iteration.
    assign short_path = (op[1] && (opb == '0)) || ovf;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        result    = '0;
        add1      = '0;
        add0      = '0;
        carry_in  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = short_path ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (op_r[1]) begin
                    // Trial subtract: t - dvs as t + ~dvs + 1.
                    add1     = div_t;
                    add0     = ~{1'b0, oper};
                    carry_in = 1'b1;
                end else begin
                    add1 = acc;
                    add0 = mq[0] ? {1'b0, oper} : '0;
                end
                if (cnt == CNT_W'(1)) begin
`ifdef MULDIV_SIGNED_EN
                    state_nxt = sgn_r ? S_FIX : S_DONE;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // op[0] selects the upper/remainder word for both MUL and DIV families.
                result    = op_r[0] ? acc[WIDTH-1:0] : mq;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mq     <= '0;
            oper   <= '0;
            cnt    <= '0;
            op_r   <= '0;
`ifdef MULDIV_SIGNED_EN
            sgn_r  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else if (accept) begin
            op_r <= op;
            cnt  <= CNT_W'(WIDTH);
            oper <= op[1] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            sgn_r  <= sgn;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
`endif
            if (op[1] && (opb == '0)) begin
                mq  <= '1;
                acc <= {1'b0, opa};
            end else if (ovf) begin
                mq  <= opa;
                acc <= '0;
            end else begin
                acc <= '0;
                mq  <= op[1] ? a_mag : b_mag;
            end
        end else if (state == S_CALC) begin
            cnt <= cnt - CNT_W'(1);
            if (op_r[1]) begin
                if (!sum[WIDTH]) begin
                    acc <= sum;
                    mq  <= {mq[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= div_t;
                    mq  <= {mq[WIDTH-2:0], 1'b0};
                end
            end else begin
                // {acc,mq} <= {sum,mq} >> 1
                acc <= {1'b0, sum[WIDTH:1]};
                mq  <= {sum[0], mq[WIDTH-1:1]};
            end
        end
`ifdef MULDIV_SIGNED_EN
        else if (state == S_FIX) begin
            if (op_r[1]) begin
                if (neg_lo) mq  <= ~mq + WIDTH'(1);
                if (neg_hi) acc <= {1'b0, ~acc[WIDTH-1:0] + WIDTH'(1)};
            end else if (neg_lo) begin
                acc <= {1'b0, prod_neg[2*WIDTH-1:WIDTH]};
                mq  <= prod_neg[WIDTH-1:0];
            end
        end
`endif
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Testbench for muldiv_seq_ctrl: scoreboard of expected results and latencies.
// Latency: checked per operation against WIDTH+1 (or 1 for fixed-answer cases).
// Backpressure: out_ready held low for a number of cycles on selected operations.
module tb_muldiv_seq_ctrl;
    localparam int W = 32;

`ifdef MULDIV_SIGNED_EN
    localparam int SGN_BUILD = 1;
`else
    localparam int SGN_BUILD = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic         sgn = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;
    logic [W:0]   add1, add0, sum;
    logic         carry_in;

    // Reference adder, combinational.
    assign sum = add1 + add0 + {{W{1'b0}}, carry_in};

    always #5 clk = ~clk;

    muldiv_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sgn(sgn), .opa(opa), .opb(opb),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy),
        .add1(add1), .add0(add0), .carry_in(carry_in), .sum(sum)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        longint sa, sbv, q, r;
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            if (!o[1]) begin
                p = 64'(sa * sbv);
                return o[0] ? p[63:32] : p[31:0];
            end
            if (b == '0) return o[0] ? a : '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[0] ? '0 : a;
            q = sa / sbv;
            r = sa % sbv;
            return o[0] ? W'(r) : W'(q);
        end
`endif
        if (!o[1]) begin
            p = 64'(a) * 64'(b);
            return o[0] ? p[63:32] : p[31:0];
        end
        if (b == '0) return o[0] ? a : '1;
        return o[0] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic s,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        if (o[1] && b == '0) return 1;
        if (SGN_BUILD == 1 && s && o[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1 + ((SGN_BUILD == 1 && s) ? 1 : 0);
    endfunction

    // Issue one request, wait for its result, optionally stall out_ready, then consume.
    task automatic run(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input int hold,
                       input string tag);
        int   lat;
        bit   got;
        exp_t e;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        op = o; sgn = s; opa = a; opb = b; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{res: res, lat: exp_lat(o, s, a, b)});
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) begin
                got = 1'b1;
            end else if (lat == 1) begin
                check({tag, "_calc_busy"}, 64'(busy), 64'd1);
                check({tag, "_calc_in_ready"}, 64'(in_ready), 64'd0);
                check({tag, "_calc_carry_in"}, 64'(carry_in), 64'(o[1]));
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            sb_q.delete();
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_result"}, 64'(result), 64'(e.res));
        check({tag, "_done_add1"}, 64'(add1), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d_valid", tag, i), 64'(out_valid), 64'd1);
            check($sformatf("%s_hold%0d_result", tag, i), 64'(result), 64'(e.res));
            check($sformatf("%s_hold%0d_in_ready", tag, i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_consumed_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_consumed_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]   ro;
        logic         rs;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_add1", 64'(add1), 64'd0);
        check("rst_add0", 64'(add0), 64'd0);
        check("rst_carry_in", 64'(carry_in), 64'd0);
        rst_n = 1'b1;

        run(2'b00, 1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 0, "mul_7x6");
        run(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulh_ff");
        run(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mul_ff");
        run(2'b10, 1'b0, 32'd100, 32'd7, 32'd14, 5, "div_100_7");
        run(2'b11, 1'b0, 32'd100, 32'd7, 32'd2, 0, "rem_100_7");
        run(2'b10, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0, "div_by0");
        run(2'b11, 1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 2, "rem_by0");
        run(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 0, "div_by1");
        run(2'b11, 1'b0, 32'd5, 32'd9, 32'd5, 0, "rem_small");

        // Abort a multiply mid-flight with reset.
        @(negedge clk);
        op = 2'b00; sgn = 1'b0; opa = 32'd3; opb = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{res: 32'd15, lat: W + 1});
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_no_valid", 64'(out_valid), 64'd0);
        run(2'b00, 1'b0, 32'd3, 32'd5, 32'd15, 0, "mul_after_abort");

`ifdef MULDIV_SIGNED_EN
        run(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "sdiv_m7_2");
        run(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "srem_m7_2");
        run(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "sdiv_ovf");
        run(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "srem_ovf");
        run(2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "smulh_m1");
        run(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 0, "smul_m3_4");
`else
        run(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0, "udiv_sgn_ignored");
`endif

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            run(ro, rs, ra, rb, model(ro, rs, ra, rb), i % 3, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Iterative multiply/divide sequencer for the ALU MulDiv unit.
- Time-shares one external (WIDTH+1)-bit adder (add1/add0/carry_in -> sum) across WIDTH iterations: shift-add multiply, restoring divide.
- Sits between the ALU issue logic (valid/ready request) and the writeback path (valid/ready result).
- Owns all operand, accumulator and counter registers; the adder stays purely combinational.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- op  in  2  00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder)
- sgn  in  1  signed-operation select (used only with SIGNED_EN)
- opa  in  WIDTH  multiplicand / dividend
- opb  in  WIDTH  multiplier / divisor
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- result  out  WIDTH  selected result word
- busy  out  1  high in CALC or DONE
- add1  out  WIDTH+1  adder operand 1
- add0  out  WIDTH+1  adder operand 0
- carry_in  out  1  adder carry in
- sum  in  WIDTH+1  adder result, same cycle (combinational)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - State = IDLE, counter = 0.
  - in_ready = 1, out_valid = 0, busy = 0, result = 0.
  - add1 = add0 = 0, carry_in = 0.
- Reset asserted mid-operation aborts the operation; no out_valid is produced.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. On handshake:
    - Latch op, sgn and operands; counter = WIDTH.
    - If op[1] = 1 and opb = 0, go to DONE directly with the divide-by-zero result.
    - Otherwise go to CALC.
  - CALC: in_ready = 0. One iteration per cycle; counter decrements each cycle. The last iteration is at counter = 1, then go to DONE.
  - DONE: out_valid = 1 and result is held stable until out_ready. On out_ready, go to IDLE. in_ready stays 0 in DONE (no overlap).
- Multiply (registers: acc WIDTH+1 bits, mq WIDTH bits initialised to opb, mcand = opa):
  - Each cycle: add1 = acc, add0 = mq[0] ? {0,mcand} : 0, carry_in = 0.
  - Then {acc,mq} <= {sum,mq} >> 1, i.e. a logical right shift of the (2*WIDTH+1)-bit concatenation.
  - Result: MUL = mq, MULH = acc[WIDTH-1:0].
- Divide (registers: rem WIDTH+1 bits init 0, q WIDTH bits init opa, dvs = opb):
  - Each cycle: t = {rem[WIDTH-1:0], q[WIDTH-1]}; add1 = t, add0 = ~{0,dvs}, carry_in = 1.
  - If sum[WIDTH] = 0: rem <= sum, q <= {q[WIDTH-2:0], 1}.
  - Otherwise: rem <= t, q <= {q[WIDTH-2:0], 0}.
  - Result: DIV = q, REM = rem[WIDTH-1:0].
- Divide by zero: DIV = all ones, REM = opa. Latency = 1 cycle (out_valid on the cycle after the handshake).
- Normal latency: out_valid rises exactly WIDTH+1 cycles after the accepting edge.
- Adder port outputs are driven only in CALC; they are 0 in IDLE and DONE.
- Back-to-back operation: the earliest next accept is the cycle after the out_valid & out_ready handshake.
- All arithmetic is modulo 2^(WIDTH+1) inside the adder. The final result is truncated to WIDTH bits.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - sgn = 1 selects signed operation. Operands are converted to magnitudes at accept (negation done in IDLE logic, not through the shared adder). Result sign is fixed up during the DONE entry cycle; latency +1 cycle.
  - MULH returns the signed high word.
  - DIV rounds toward zero; REM takes the sign of the dividend.
  - Overflow case (opa = most-negative, opb = -1, op[1] = 1): DIV = opa, REM = 0, 1-cycle latency.
- Undefined: sgn is ignored; all operations are unsigned; no extra latency.

Test Plan:
- MUL, WIDTH=32, opa=0x0000_0007, opb=0x0000_0006 -> result=0x0000_002A, out_valid exactly 33 cycles after accept.
- MULH, opa=0xFFFF_FFFF, opb=0xFFFF_FFFF (unsigned) -> result=0xFFFF_FFFE; same operands with MUL -> 0x0000_0001.
- DIV/REM, opa=100, opb=7 -> DIV=14, REM=2; hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
- DIV by zero, opa=0x1234_5678, opb=0 -> DIV=0xFFFF_FFFF, REM=0x1234_5678, out_valid 1 cycle after accept.
- rst_n=0 at CALC iteration 10 -> next cycle IDLE, in_ready=1, out_valid=0; a fresh MUL then completes correctly.
- With MULDIV_SIGNED_EN: DIV sgn=1, opa=-7, opb=2 -> DIV=-3, REM=-1; opa=0x8000_0000, opb=0xFFFF_FFFF -> DIV=0x8000_0000, REM=0.
